// File: rtl/pc_stack_sequencer_if.sv
// Bus between cpu_control and the PC/address-stack sequencer.
// master = control side, slave = sequencer side.
interface pc_stack_sequencer_if #(parameter int DEPTH = 4);
   localparam int SPW = $clog2(DEPTH);

   logic [2:0]     cycle;
   logic [2:0]     pc_write_enable;
   logic [1:0]     pc_next_sel;
   logic [3:0]     data;
   logic [3:0]     inst_operand;
   logic [3:0]     reg_value;
   logic           inc_inhibit;
   logic           push;
   logic           pop;
   logic [3:0]     addr_out;
   logic [11:0]    pc;
   logic [SPW-1:0] sp;
   logic           overflow;
   logic           underflow;

   modport master (
      output cycle, pc_write_enable, pc_next_sel, data, inst_operand, reg_value,
             inc_inhibit, push, pop,
      input  addr_out, pc, sp, overflow, underflow
   );

   modport slave (
      input  cycle, pc_write_enable, pc_next_sel, data, inst_operand, reg_value,
             inc_inhibit, push, pop,
      output addr_out, pc, sp, overflow, underflow
   );
endinterface

// File: rtl/pc_stack_sequencer.sv
// Program counter plus return-address stack: serializes the PC onto the
// address nibble, increments it nibble-serially, applies nibble writes, push/pop.
module pc_stack_sequencer #(
   parameter int DEPTH = 4
) (
   input logic                 clock,
   input logic                 reset_n,
   pc_stack_sequencer_if.slave bus
);
   localparam int SPW = $clog2(DEPTH);
   localparam logic [1:0] PC_FROM_DATA = 2'd0;
   localparam logic [1:0] PC_FROM_INST = 2'd1;
   localparam logic [1:0] PC_FROM_REG  = 2'd2;

   logic [11:0]    level [DEPTH];
   logic [SPW-1:0] sp, sp_up, sp_dn;
   logic [SPW-1:0] depth_cnt;
   logic           inc_carry, inc_en;
   logic           overflow, underflow;
   logic [11:0]    cur, inc_pc, wr_pc;
   logic           carry_nxt;
   logic [3:0]     src;
   logic           src_ok;
   logic           do_push, do_pop;
   logic           carry_in;

   assign cur      = level[sp];
   assign sp_up    = sp + SPW'(1);
   assign sp_dn    = sp - SPW'(1);
   assign do_push  = bus.push && (bus.cycle == 3'd2);
   assign do_pop   = bus.pop  && (bus.cycle == 3'd6);
   assign carry_in = inc_carry & inc_en;

   assign bus.pc        = cur;
   assign bus.sp        = sp;
   assign bus.overflow  = overflow;
   assign bus.underflow = underflow;

   always_comb begin
      bus.addr_out = 4'h0;
      case (bus.cycle)
         3'd0:    bus.addr_out = cur[3:0];
         3'd1:    bus.addr_out = cur[7:4];
         3'd2:    bus.addr_out = cur[11:8];
         default: bus.addr_out = 4'h0;
      endcase
   end

   always_comb begin
      inc_pc    = cur;
      carry_nxt = 1'b0;
      case (bus.cycle)
         3'd0: if (!bus.inc_inhibit) {carry_nxt, inc_pc[3:0]} = {1'b0, cur[3:0]} + 5'd1;
         3'd1: {carry_nxt, inc_pc[7:4]} = {1'b0, cur[7:4]} + {4'd0, carry_in};
         3'd2: inc_pc[11:8] = cur[11:8] + {3'd0, carry_in};
         default: carry_nxt = 1'b0;
      endcase

      src    = 4'h0;
      src_ok = 1'b1;
      case (bus.pc_next_sel)
         PC_FROM_DATA: src = bus.data;
         PC_FROM_INST: src = bus.inst_operand;
         PC_FROM_REG:  src = bus.reg_value;
         default:      src_ok = 1'b0;
      endcase

      // Writes win over the increment; a written nibble never carries out.
      wr_pc = inc_pc;
      if (src_ok) begin
         if (bus.pc_write_enable[0]) wr_pc[3:0]  = src;
         if (bus.pc_write_enable[1]) wr_pc[7:4]  = src;
         if (bus.pc_write_enable[2]) wr_pc[11:8] = src;
         if ((bus.pc_write_enable[0] && bus.cycle == 3'd0) ||
             (bus.pc_write_enable[1] && bus.cycle == 3'd1))
            carry_nxt = 1'b0;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < DEPTH; i++) level[i] <= '0;
         sp        <= '0;
         depth_cnt <= '0;
         inc_carry <= 1'b0;
         inc_en    <= 1'b0;
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         inc_carry <= carry_nxt;
         if (bus.cycle == 3'd0) inc_en <= ~bus.inc_inhibit;
         if (do_push) begin
            // Return address keeps the finished increment; the new level starts
            // from it and takes this edge's writes.
            level[sp]    <= inc_pc;
            level[sp_up] <= wr_pc;
            sp           <= sp_up;
            if (depth_cnt == SPW'(DEPTH - 1)) overflow <= 1'b1;
            else                              depth_cnt <= depth_cnt + SPW'(1);
         end else begin
            level[sp] <= wr_pc;
            if (do_pop) begin
               sp <= sp_dn;
               if (depth_cnt == '0) underflow <= 1'b1;
               else                 depth_cnt <= depth_cnt - SPW'(1);
            end
         end
      end
   end
endmodule

// File: tb/tb_pc_stack_sequencer.sv
// Directed bench for pc_stack_sequencer: fetch nibbles go through a scoreboard
// queue, PC/stack state is checked against constants after each instruction cycle.
module tb_pc_stack_sequencer;
   localparam int DEPTH = 4;
   localparam logic [1:0] SEL_DATA = 2'd0;
   localparam logic [1:0] SEL_INST = 2'd1;
   localparam logic [1:0] SEL_REG  = 2'd2;
   localparam logic [1:0] SEL_NONE = 2'd3;

   logic clock   = 1'b0;
   logic reset_n = 1'b1;
   int   checks  = 0;
   int   errors  = 0;
   logic [3:0] exp_q [$];

   pc_stack_sequencer_if #(.DEPTH(DEPTH)) bus ();
   pc_stack_sequencer #(.DEPTH(DEPTH)) dut (.clock(clock), .reset_n(reset_n), .bus(bus));

   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One subcycle: drive after the edge, sample addr_out on the falling edge.
   task automatic sub(input logic [2:0] c, input logic [2:0] we, input logic [1:0] sel,
                      input logic [3:0] d, input logic inh, input logic ps, input logic pp);
      bus.cycle           = c;
      bus.pc_write_enable = we;
      bus.pc_next_sel     = sel;
      bus.data            = (sel == SEL_DATA) ? d : ~d;
      bus.inst_operand    = (sel == SEL_INST) ? d : ~d;
      bus.reg_value       = (sel == SEL_REG)  ? d : ~d;
      bus.inc_inhibit     = inh;
      bus.push            = ps;
      bus.pop             = pp;
      @(negedge clock);
      if (c < 3'd3) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL addr_queue_empty observed=%0h expected=none", bus.addr_out);
         end else chk("addr_fetch", bus.addr_out, exp_q.pop_front());
      end else chk("addr_idle", bus.addr_out, 16'h0);
      @(posedge clock);
      #1;
   endtask

   // Full instruction cycle; optional jump writes bit1, bit0 (jsel) then bit2 (INST).
   task automatic icycle(input logic [11:0] fetch, input logic inh, input logic ps,
                         input logic pp, input logic jmp, input logic [1:0] jsel,
                         input logic [11:0] tgt);
      exp_q.push_back(fetch[3:0]);
      exp_q.push_back(fetch[7:4]);
      exp_q.push_back(fetch[11:8]);
      sub(3'd0, 3'b000, SEL_NONE, 4'h0, inh, ps, pp);
      sub(3'd1, 3'b000, SEL_NONE, 4'h0, inh, ps, pp);
      sub(3'd2, 3'b000, SEL_NONE, 4'h0, inh, ps, pp);
      sub(3'd3, jmp ? 3'b010 : 3'b000, jsel, tgt[7:4], inh, ps, pp);
      sub(3'd4, jmp ? 3'b001 : 3'b000, jsel, tgt[3:0], inh, ps, pp);
      sub(3'd5, jmp ? 3'b100 : 3'b000, SEL_INST, tgt[11:8], inh, ps, pp);
      sub(3'd6, 3'b000, SEL_NONE, 4'h0, inh, ps, pp);
      sub(3'd7, 3'b000, SEL_NONE, 4'h0, inh, ps, pp);
   endtask

   initial begin
      bus.cycle = 3'd0; bus.pc_write_enable = 3'b000; bus.pc_next_sel = SEL_NONE;
      bus.data = 4'h0; bus.inst_operand = 4'h0; bus.reg_value = 4'h0;
      bus.inc_inhibit = 1'b0; bus.push = 1'b0; bus.pop = 1'b0;
      #1 reset_n = 1'b0;
      #2;
      chk("rst_pc", bus.pc, 16'h000);
      chk("rst_sp", bus.sp, 16'h0);
      chk("rst_ovf", bus.overflow, 16'h0);
      chk("rst_unf", bus.underflow, 16'h0);
      chk("rst_addr", bus.addr_out, 16'h0);
      @(posedge clock); #1;
      reset_n = 1'b1;

      // Carry across nibbles
      icycle(12'h000, 1'b1, 1'b0, 1'b0, 1'b1, SEL_DATA, 12'h0FF);
      chk("load_0ff", bus.pc, 16'h0FF);
      icycle(12'h0FF, 1'b0, 1'b0, 1'b0, 1'b0, SEL_NONE, 12'h000);
      chk("carry_pc", bus.pc, 16'h100);

      // Wrap-around and inhibit
      icycle(12'h100, 1'b1, 1'b0, 1'b0, 1'b1, SEL_DATA, 12'hFFF);
      icycle(12'hFFF, 1'b0, 1'b0, 1'b0, 1'b0, SEL_NONE, 12'h000);
      chk("wrap_pc", bus.pc, 16'h000);
      chk("wrap_ovf", bus.overflow, 16'h0);
      icycle(12'h000, 1'b1, 1'b0, 1'b0, 1'b1, SEL_DATA, 12'hFFF);
      icycle(12'hFFF, 1'b1, 1'b0, 1'b0, 1'b0, SEL_NONE, 12'h000);
      chk("inhibit_pc", bus.pc, 16'hFFF);

      // Jumps through each source and a suppressed selector
      icycle(12'hFFF, 1'b1, 1'b0, 1'b0, 1'b1, SEL_DATA, 12'h3A5);
      chk("jump_data", bus.pc, 16'h3A5);
      icycle(12'h3A5, 1'b1, 1'b0, 1'b0, 1'b1, SEL_REG, 12'h7C2);
      chk("jump_reg", bus.pc, 16'h7C2);
      icycle(12'h7C2, 1'b1, 1'b0, 1'b0, 1'b1, SEL_NONE, 12'h9DE);
      chk("jump_nosel", bus.pc, 16'h9C2);

      // Call and return
      icycle(12'h9C2, 1'b1, 1'b0, 1'b0, 1'b1, SEL_DATA, 12'h120);
      icycle(12'h120, 1'b0, 1'b1, 1'b0, 1'b1, SEL_DATA, 12'h456);
      chk("call_sp", bus.sp, 16'h1);
      chk("call_pc", bus.pc, 16'h456);
      icycle(12'h456, 1'b1, 1'b0, 1'b1, 1'b0, SEL_NONE, 12'h000);
      chk("ret_sp", bus.sp, 16'h0);
      chk("ret_pc", bus.pc, 16'h121);
      icycle(12'h121, 1'b0, 1'b0, 1'b0, 1'b0, SEL_NONE, 12'h000);
      chk("ret_inc_pc", bus.pc, 16'h122);
      chk("ret_unf", bus.underflow, 16'h0);

      // Overflow: fourth push wraps sp and sets the flag
      for (int i = 1; i <= 4; i++) begin
         icycle(12'h122, 1'b1, 1'b1, 1'b0, 1'b0, SEL_NONE, 12'h000);
         chk("push_sp", bus.sp, 16'(i % DEPTH));
         chk("push_ovf", bus.overflow, (i == 4) ? 16'h1 : 16'h0);
      end
      // Only three valid levels remain, so the fourth pop underflows
      for (int i = 1; i <= 4; i++) begin
         icycle(12'h122, 1'b1, 1'b0, 1'b1, 1'b0, SEL_NONE, 12'h000);
         chk("pop_sp", bus.sp, 16'((DEPTH - i) % DEPTH));
         chk("pop_unf", bus.underflow, (i == 4) ? 16'h1 : 16'h0);
      end

      // Asynchronous reset partway through an increment
      icycle(12'h122, 1'b1, 1'b0, 1'b0, 1'b1, SEL_DATA, 12'h0FF);
      chk("pre_rst_pc", bus.pc, 16'h0FF);
      exp_q.push_back(4'hF);
      sub(3'd0, 3'b000, SEL_NONE, 4'h0, 1'b0, 1'b0, 1'b0);
      bus.cycle = 3'd1;
      #2 reset_n = 1'b0;
      #1;
      chk("arst_pc", bus.pc, 16'h000);
      chk("arst_addr", bus.addr_out, 16'h0);
      chk("arst_sp", bus.sp, 16'h0);
      chk("arst_ovf", bus.overflow, 16'h0);
      chk("arst_unf", bus.underflow, 16'h0);
      bus.cycle = 3'd7;
      #3 reset_n = 1'b1;
      @(posedge clock); #1;
      icycle(12'h000, 1'b1, 1'b0, 1'b0, 1'b0, SEL_NONE, 12'h000);
      chk("post_rst_pc", bus.pc, 16'h000);

      // Underflow straight from reset
      icycle(12'h000, 1'b1, 1'b0, 1'b1, 1'b0, SEL_NONE, 12'h000);
      chk("unf_flag", bus.underflow, 16'h1);
      chk("unf_sp", bus.sp, 16'(DEPTH - 1));
      chk("unf_pc", bus.pc, 16'h000);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
